// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO behind a valid/ready handshake feeding a
// start/data/parity/stop serializer whose outputs are all registered.
module uart_tx_buffered #(
  parameter int CLK_PER_BIT = 868,
  parameter int PACK_SIZE   = 8,
  parameter int PARITY_EN   = 1,
  parameter int EVEN_PAR    = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          tx_byte_valid,
  input  logic [PACK_SIZE-1:0]          tx_byte_data,
  output logic                          tx_ready,
  output logic                          tx_bit,
  output logic                          tx_active,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int STOP_CYC = STOP_BITS * CLK_PER_BIT;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int BW       = $clog2(PACK_SIZE + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [PACK_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [PACK_SIZE-1:0] shift;
  logic                 par;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 wr_en, pop, bit_last, stop_last, fifo_empty;

  assign tx_ready   = fifo_count != (AW+1)'(FIFO_DEPTH);
  assign wr_en      = tx_byte_valid && tx_ready;
  assign fifo_empty = fifo_count == '0;
  assign bit_last   = cnt == CW'(CLK_PER_BIT - 1);
  assign stop_last  = cnt == CW'(STOP_CYC - 1);
  // The serializer pulls the head when idle or on the final stop cycle (back-to-back).
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && stop_last));

  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) mem[wr_ptr] <= tx_byte_data;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= tx_byte_valid && !tx_ready;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Line outputs follow the state one edge later, so every bit keeps its full width.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state     <= IDLE;
      tx_bit    <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par       <= 1'b0;
    end else begin
      tx_active <= state != IDLE;
      tx_done   <= (state == STOP) && stop_last;
      case (state)
        START:   tx_bit <= 1'b0;
        DATA:    tx_bit <= shift[0];
        PARITY:  tx_bit <= par;
        default: tx_bit <= 1'b1;
      endcase

      if (pop) begin
        shift <= mem[rd_ptr];
        par   <= (^mem[rd_ptr]) ^ (EVEN_PAR == 0);
        cnt   <= '0;
        state <= START;
      end else begin
        case (state)
          IDLE: cnt <= '0;
          START:
            if (bit_last) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end else cnt <= cnt + 1'b1;
          DATA:
            if (bit_last) begin
              cnt   <= '0;
              shift <= shift >> 1;
              if (bit_idx == BW'(PACK_SIZE - 1))
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              else
                bit_idx <= bit_idx + 1'b1;
            end else cnt <= cnt + 1'b1;
          PARITY:
            if (bit_last) begin
              cnt   <= '0;
              state <= STOP;
            end else cnt <= cnt + 1'b1;
          STOP:
            if (stop_last) begin
              cnt   <= '0;
              state <= IDLE;
            end else cnt <= cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: three transmitter configurations, stimulus pushes expected
// frames, per-DUT monitors decode the line cycle by cycle and compare.
module tb_uart_tx_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       vld [3];
  logic [7:0] dat [3];
  logic       rdy [3], txb [3], act [3], done [3], ovf [3];
  logic [4:0] cnt [3];

  typedef struct packed {logic [7:0] d; logic p; logic b2b;} exp_t;
  exp_t q [3][$];

  int   checks = 0, errors = 0, ovf_cnt = 0;
  int   done_cnt [3];
  logic mon_on [3];

  task automatic chk(input string nm, input integer a, input integer e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // dut0: even parity, 1 stop; dut1: odd parity, 2 stop; dut2: no parity, 1 stop
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PEN  = (g == 2) ? 0 : 1;
    localparam int EVP  = (g == 1) ? 0 : 1;
    localparam int SBS  = (g == 1) ? 2 : 1;
    localparam int NB   = 1 + 8 + PEN + SBS;
    localparam int FLEN = NB * 16;

    uart_tx_buffered #(.CLK_PER_BIT(16), .PACK_SIZE(8), .PARITY_EN(PEN), .EVEN_PAR(EVP),
                       .STOP_BITS(SBS), .FIFO_DEPTH(16)) u_dut (
      .CLK100MHZ(clk), .reset(reset), .tx_byte_valid(vld[g]), .tx_byte_data(dat[g]),
      .tx_ready(rdy[g]), .tx_bit(txb[g]), .tx_active(act[g]), .tx_done(done[g]),
      .fifo_count(cnt[g]), .overflow(ovf[g]));

    initial begin : mon
      logic          have;
      exp_t          e;
      logic [NB-1:0] bits, bad;
      logic          abad, dbad;
      have = 1'b0;
      forever begin
        if (!have) @(negedge clk);
        have = 1'b0;
        if (mon_on[g] === 1'b1 && txb[g] === 1'b0) begin
          chk($sformatf("dut%0d_frame_expected", g), int'(q[g].size() > 0), 1);
          e = (q[g].size() > 0) ? q[g].pop_front() : '0;
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
          if (PEN != 0) bits[9] = e.p;
          bad = '0; abad = 1'b0; dbad = 1'b0;
          for (int c = 0; c < FLEN; c++) begin
            if (txb[g] !== bits[c/16]) bad[c/16] = 1'b1;
            if (act[g] !== 1'b1) abad = 1'b1;
            if (done[g] !== (c == FLEN - 1)) dbad = 1'b1;
            if (c < FLEN - 1) @(negedge clk);
          end
          for (int b = 0; b < NB; b++)
            chk($sformatf("dut%0d_byte%02h_bit%0d", g, e.d, b),
                bad[b] ? integer'(!bits[b]) : integer'(bits[b]), integer'(bits[b]));
          chk($sformatf("dut%0d_byte%02h_active", g, e.d), abad, 0);
          chk($sformatf("dut%0d_byte%02h_done_timing", g, e.d), dbad, 0);
          @(negedge clk);
          have = 1'b1;
          if (q[g].size() != 0 && q[g][0].b2b)
            chk($sformatf("dut%0d_b2b_start", g), txb[g], 0);
          else if (q[g].size() == 0) begin
            chk($sformatf("dut%0d_idle_line", g), txb[g], 1);
            chk($sformatf("dut%0d_idle_active", g), act[g], 0);
          end
          done_cnt[g]++;
        end
      end
    end
  end

  always @(negedge clk) if (ovf[0] === 1'b1) ovf_cnt++;

  task automatic send(input int g, input logic [7:0] d, input logic p, input logic b2b,
                      input logic push);
    int t = 0;
    @(negedge clk);
    while (rdy[g] !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk($sformatf("dut%0d_ready_wait", g), rdy[g], 1);
    vld[g] = 1'b1;
    dat[g] = d;
    @(posedge clk);
    if (push) q[g].push_back(exp_t'{d, p, b2b});
    #1 vld[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target);
    int t = 0;
    while (done_cnt[g] < target && t < 60000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("dut%0d_frames_done", g), done_cnt[g], target);
  endtask

  initial begin
    logic [7:0] d;
    int         bad;
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      vld[g] = 1'b0; dat[g] = '0; mon_on[g] = 1'b1; done_cnt[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("dut%0d_rst_txbit", g), txb[g], 1);
      chk($sformatf("dut%0d_rst_active", g), act[g], 0);
      chk($sformatf("dut%0d_rst_done", g), done[g], 0);
      chk($sformatf("dut%0d_rst_ovf", g), ovf[g], 0);
      chk($sformatf("dut%0d_rst_count", g), cnt[g], 0);
      chk($sformatf("dut%0d_rst_ready", g), rdy[g], 1);
    end
    @(negedge clk) reset = 1'b0;

    // 0xA5, even parity 0; line falls two edges after the write edge
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 chk("latency_n1_txbit", txb[0], 1);
    @(posedge clk); #1 chk("latency_n2_txbit", txb[0], 0);
    chk("latency_n2_active", act[0], 1);
    wait_done(0, 1);

    // 0x07: even -> 1, odd -> 0, no parity -> 10-bit frame
    send(0, 8'h07, 1'b1, 1'b0, 1'b1); wait_done(0, 2);
    send(1, 8'h07, 1'b0, 1'b0, 1'b1); wait_done(1, 1);
    send(2, 8'h07, 1'b0, 1'b0, 1'b1); wait_done(2, 1);

    // two stop bits, second frame back-to-back (odd parity: 0x3A -> 1, 0xC1 -> 0)
    send(1, 8'h3A, 1'b1, 1'b0, 1'b1);
    send(1, 8'hC1, 1'b0, 1'b1, 1'b1);
    wait_done(1, 3);

    // 18 consecutive valid cycles from empty: 17 accepted, 18th overflows
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      d = 8'(8'h40 + i);
      vld[0] = 1'b1;
      dat[0] = d;
      @(posedge clk);
      if (i < 17) q[0].push_back(exp_t'{d, ^d, i != 0});
      #1;
      if (i == 16) begin
        chk("burst_ready_low", rdy[0], 0);
        chk("burst_count_full", cnt[0], 16);
      end
      if (i == 17) begin
        chk("burst_overflow", ovf[0], 1);
        chk("burst_count_held", cnt[0], 16);
      end
    end
    vld[0] = 1'b0;
    @(posedge clk); #1 chk("burst_overflow_strobe", ovf[0], 0);
    wait_done(0, 19);

    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      send(0, d, ^d, 1'b0, 1'b1);
    end
    wait_done(0, 275);

    // reset mid-DATA with 5 bytes queued
    mon_on[0] = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
    chk("abort_queued", cnt[0], 5);
    repeat (60) @(negedge clk);
    chk("abort_active_before", act[0], 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_txbit", txb[0], 1);
    chk("abort_active", act[0], 0);
    chk("abort_count", cnt[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_ready", rdy[0], 1);
    @(negedge clk) reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (txb[0] !== 1'b1 || done[0] !== 1'b0 || act[0] !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    mon_on[0] = 1'b1;
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_done(0, 276);

    repeat (20) @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("dut%0d_queue_empty", g), q[g].size(), 0);
    chk("overflow_pulses", ovf_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
